// File: rtl/div_pkg.sv
// Shared definitions for the divide issue controller: funct3 encodings,
// controller state encoding and the post-reset quiesce default.
package div_pkg;

    localparam logic [2:0] FUNCT3_DIV  = 3'b100;
    localparam logic [2:0] FUNCT3_DIVU = 3'b101;
    localparam logic [2:0] FUNCT3_REM  = 3'b110;
    localparam logic [2:0] FUNCT3_REMU = 3'b111;

    localparam int DEFAULT_OPERAND_SIZE = 32;
    localparam int QUIESCE_MARGIN       = 4;

    typedef logic [2:0] div_state_t;

    localparam div_state_t S_QUIESCE = 3'd0;
    localparam div_state_t S_IDLE    = 3'd1;
    localparam div_state_t S_LAUNCH  = 3'd2;
    localparam div_state_t S_WAIT    = 3'd3;
    localparam div_state_t S_RESP    = 3'd4;

    typedef struct packed {
        logic is_signed;
        logic is_rem;
    } op_kind_t;

    function automatic int quiesce_default(input int operand_size);
        return operand_size + QUIESCE_MARGIN;
    endfunction

    // Unknown funct3 codes fall through to the DIVU behaviour.
    function automatic op_kind_t decode_op(input logic [2:0] funct3);
        op_kind_t kind;
        kind.is_signed = 1'b0;
        kind.is_rem    = 1'b0;
        case (funct3)
            FUNCT3_DIV:  kind.is_signed = 1'b1;
            FUNCT3_DIVU: kind.is_signed = 1'b0;
            FUNCT3_REM: begin
                kind.is_signed = 1'b1;
                kind.is_rem    = 1'b1;
            end
            FUNCT3_REMU: kind.is_rem = 1'b1;
            default: ;
        endcase
        return kind;
    endfunction

endpackage

// File: rtl/div_special_case.sv
// Combinational detection of the divide cases that bypass the iterative
// divider (divide-by-zero, signed overflow) and their architectural result.
module div_special_case
    import div_pkg::*;
#(
    parameter int OPERAND_SIZE = DEFAULT_OPERAND_SIZE
) (
    input  logic [2:0]              funct3_i,
    input  logic [OPERAND_SIZE-1:0] rs1_i,
    input  logic [OPERAND_SIZE-1:0] rs2_i,
    output logic                    bypass_o,
    output logic [OPERAND_SIZE-1:0] result_o
);

    localparam logic [OPERAND_SIZE-1:0] MOST_NEGATIVE = {1'b1, {(OPERAND_SIZE-1){1'b0}}};

    op_kind_t kind;
    logic     div_by_zero;
    logic     overflow;

    assign kind        = decode_op(funct3_i);
    assign div_by_zero = (rs2_i == '0);
    assign overflow    = kind.is_signed && (rs1_i == MOST_NEGATIVE) && (rs2_i == '1);
    assign bypass_o    = div_by_zero || overflow;

    // Divide-by-zero wins when both conditions could apply.
    always_comb begin
        result_o = '0;
        if (div_by_zero) begin
            result_o = kind.is_rem ? rs1_i : '1;
        end else if (overflow) begin
            result_o = kind.is_rem ? '0 : rs1_i;
        end
    end

endmodule

// File: rtl/div_issue_ctrl.sv
// Issue/response sequencer for an external iterative divider: accepts one
// op at a time, short-circuits special cases and holds the result for writeback.
module div_issue_ctrl
    import div_pkg::*;
#(
    parameter int OPERAND_SIZE   = DEFAULT_OPERAND_SIZE,
    parameter int QUIESCE_CYCLES = quiesce_default(OPERAND_SIZE)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    op_valid_i,
    output logic                    op_ready_o,
    input  logic [2:0]              funct3_i,
    input  logic [OPERAND_SIZE-1:0] rs1_i,
    input  logic [OPERAND_SIZE-1:0] rs2_i,
    input  logic [4:0]              rd_i,
    output logic                    div_load_o,
    output logic [OPERAND_SIZE-1:0] div_dividend_o,
    output logic [OPERAND_SIZE-1:0] div_divisor_o,
    output logic                    div_signed_o,
    input  logic                    div_rdy_i,
    input  logic [OPERAND_SIZE-1:0] div_quotient_i,
    input  logic [OPERAND_SIZE-1:0] div_remainder_i,
    output logic                    res_valid_o,
    input  logic                    res_ready_i,
    output logic [OPERAND_SIZE-1:0] res_data_o,
    output logic [4:0]              res_rd_o
);

    localparam int CW = $clog2(QUIESCE_CYCLES + 1);

    div_state_t              state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [2:0]              funct3_q, funct3_d;
    logic [4:0]              rd_q, rd_d;
    logic [OPERAND_SIZE-1:0] dividend_q, dividend_d;
    logic [OPERAND_SIZE-1:0] divisor_q, divisor_d;
    logic                    signed_q, signed_d;
    logic [OPERAND_SIZE-1:0] res_data_q, res_data_d;

    logic                    bypass;
    logic [OPERAND_SIZE-1:0] bypass_result;
    op_kind_t                kind_in;
    op_kind_t                kind_q;

    // Checked on the values being captured so a bypass result lands in the same edge.
    div_special_case #(
        .OPERAND_SIZE(OPERAND_SIZE)
    ) u_special (
        .funct3_i (funct3_i),
        .rs1_i    (rs1_i),
        .rs2_i    (rs2_i),
        .bypass_o (bypass),
        .result_o (bypass_result)
    );

    assign kind_in = decode_op(funct3_i);
    assign kind_q  = decode_op(funct3_q);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        funct3_d   = funct3_q;
        rd_d       = rd_q;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        signed_d   = signed_q;
        res_data_d = res_data_q;
        case (state_q)
            S_QUIESCE: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_IDLE: begin
                if (op_valid_i) begin
                    funct3_d   = funct3_i;
                    rd_d       = rd_i;
                    dividend_d = rs1_i;
                    divisor_d  = rs2_i;
                    signed_d   = kind_in.is_signed;
                    if (bypass) begin
                        res_data_d = bypass_result;
                        state_d    = S_RESP;
                    end else begin
                        state_d = S_LAUNCH;
                    end
                end
            end
            S_LAUNCH: state_d = S_WAIT;
            S_WAIT: begin
                if (div_rdy_i) begin
                    res_data_d = kind_q.is_rem ? div_remainder_i : div_quotient_i;
                    state_d    = S_RESP;
                end
            end
            S_RESP: begin
                if (res_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_QUIESCE;
        endcase
    end

    // The quiesce countdown covers any divide still running inside the unresettable divider.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_QUIESCE;
            cnt_q      <= CW'(QUIESCE_CYCLES - 1);
            funct3_q   <= '0;
            rd_q       <= '0;
            dividend_q <= '0;
            divisor_q  <= '0;
            signed_q   <= 1'b0;
            res_data_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            funct3_q   <= funct3_d;
            rd_q       <= rd_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            signed_q   <= signed_d;
            res_data_q <= res_data_d;
        end
    end

    assign op_ready_o     = (state_q == S_IDLE);
    assign div_load_o     = (state_q == S_LAUNCH);
    assign res_valid_o    = (state_q == S_RESP);
    assign div_dividend_o = dividend_q;
    assign div_divisor_o  = divisor_q;
    assign div_signed_o   = signed_q;
    assign res_data_o     = res_data_q;
    assign res_rd_o       = rd_q;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Bench for div_issue_ctrl paired with a behavioural stand-in for int_div_32;
// directed scenarios followed by randomized ops against a reference model.
module tb_div_issue_ctrl;

    localparam int W              = 32;
    localparam int QC             = W + 4;
    localparam int NORMAL_LATENCY = 34;
    localparam int DIV_EDGES      = 31;

    logic         clk = 1'b0;
    logic         rst;
    logic         opValid;
    logic         opReady;
    logic [2:0]   funct3;
    logic [W-1:0] rs1;
    logic [W-1:0] rs2;
    logic [4:0]   rd;
    logic         divLoad;
    logic [W-1:0] divDividend;
    logic [W-1:0] divDivisor;
    logic         divSigned;
    logic         resValid;
    logic         resReady;
    logic [W-1:0] resData;
    logic [4:0]   resRd;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Stand-in for int_div_32: loads on the strobe, raises result_rdy DIV_EDGES edges later
    // and keeps it high until the next load; it has no reset.
    logic [W-1:0] divQ   = '0;
    logic [W-1:0] divR   = '0;
    logic         divRdy = 1'b0;
    int           divCnt = 0;

    always @(posedge clk) begin
        if (divLoad) begin
            divRdy <= 1'b0;
            divCnt <= DIV_EDGES;
            if (divDivisor == '0) begin
                divQ <= '1;
                divR <= divDividend;
            end else if (divSigned && divDividend == 32'h8000_0000 && divDivisor == 32'hFFFF_FFFF) begin
                divQ <= divDividend;
                divR <= '0;
            end else if (divSigned) begin
                divQ <= $signed(divDividend) / $signed(divDivisor);
                divR <= $signed(divDividend) % $signed(divDivisor);
            end else begin
                divQ <= divDividend / divDivisor;
                divR <= divDividend % divDivisor;
            end
        end else if (divCnt > 0) begin
            divCnt <= divCnt - 1;
            if (divCnt == 1) begin
                divRdy <= 1'b1;
            end
        end
    end

    div_issue_ctrl #(
        .OPERAND_SIZE   (W),
        .QUIESCE_CYCLES (QC)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .op_valid_i      (opValid),
        .op_ready_o      (opReady),
        .funct3_i        (funct3),
        .rs1_i           (rs1),
        .rs2_i           (rs2),
        .rd_i            (rd),
        .div_load_o      (divLoad),
        .div_dividend_o  (divDividend),
        .div_divisor_o   (divDivisor),
        .div_signed_o    (divSigned),
        .div_rdy_i       (divRdy),
        .div_quotient_i  (divQ),
        .div_remainder_i (divR),
        .res_valid_o     (resValid),
        .res_ready_i     (resReady),
        .res_data_o      (resData),
        .res_rd_o        (resRd)
    );

    function automatic logic refSigned(input logic [2:0] f);
        return (f == 3'b100) || (f == 3'b110);
    endfunction

    function automatic logic refRem(input logic [2:0] f);
        return (f == 3'b110) || (f == 3'b111);
    endfunction

    function automatic logic refBypass(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
        return (b == '0) || (refSigned(f) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    // Architectural divide result straight from the RISC-V M-extension rules.
    function automatic logic [W-1:0] refResult(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] r;
        if (b == '0) begin
            r = refRem(f) ? a : 32'hFFFF_FFFF;
        end else if (refSigned(f) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            r = refRem(f) ? 32'h0 : a;
        end else if (refSigned(f)) begin
            if (refRem(f)) r = $signed(a) % $signed(b);
            else           r = $signed(a) / $signed(b);
        end else begin
            if (refRem(f)) r = a % b;
            else           r = a / b;
        end
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Called at a negedge; returns at the negedge following the accept edge.
    task automatic applyStimulus(input string name, input logic [2:0] f, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input logic [4:0] r);
        int waitCycles;
        waitCycles = 0;
        while (!opReady && waitCycles < 100) begin
            @(negedge clk);
            waitCycles++;
        end
        checkOutput({name, ":readyBeforeAccept"}, 64'(opReady), 64'(1));
        opValid = 1'b1;
        funct3  = f;
        rs1     = a;
        rs2     = b;
        rd      = r;
        @(posedge clk);
        @(negedge clk);
        opValid = 1'b0;
        funct3  = 3'($urandom);
        rs1     = $urandom;
        rs2     = $urandom;
        rd      = 5'($urandom);
    endtask

    task automatic runTransaction(input string name, input logic [2:0] f, input logic [W-1:0] a,
                                  input logic [W-1:0] b, input logic [4:0] r, input int stall);
        logic [W-1:0] expData;
        int           expLat;
        int           lat;
        int           loads;
        expData = refResult(f, a, b);
        expLat  = refBypass(f, a, b) ? 1 : NORMAL_LATENCY;
        lat     = 0;
        loads   = 0;
        applyStimulus(name, f, a, b, r);
        for (int n = 1; n <= 100 && lat == 0; n++) begin
            checkOutput({name, ":exclusive"}, 64'(resValid & divLoad), 64'(0));
            checkOutput({name, ":busyNotReady"}, 64'(opReady), 64'(0));
            if (divLoad) begin
                loads++;
                checkOutput({name, ":divSigned"}, 64'(divSigned), 64'(refSigned(f)));
                checkOutput({name, ":dividend"}, 64'(divDividend), 64'(a));
                checkOutput({name, ":divisor"}, 64'(divDivisor), 64'(b));
            end
            if (resValid) lat = n;
            else          @(negedge clk);
        end
        checkOutput({name, ":latency"}, 64'(lat), 64'(expLat));
        checkOutput({name, ":loadPulses"}, 64'(loads), 64'(expLat == 1 ? 0 : 1));
        checkOutput({name, ":data"}, 64'(resData), 64'(expData));
        checkOutput({name, ":rd"}, 64'(resRd), 64'(r));
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            checkOutput({name, ":holdValid"}, 64'(resValid), 64'(1));
            checkOutput({name, ":holdData"}, 64'(resData), 64'(expData));
            checkOutput({name, ":holdRd"}, 64'(resRd), 64'(r));
            checkOutput({name, ":holdNotReady"}, 64'(opReady), 64'(0));
        end
        resReady = 1'b1;
        @(negedge clk);
        resReady = 1'b0;
        checkOutput({name, ":validDropped"}, 64'(resValid), 64'(0));
        checkOutput({name, ":readyAfterHandshake"}, 64'(opReady), 64'(1));
    endtask

    // Called at the first negedge after the last reset edge.
    task automatic quiesceCheck(input string name);
        int lowCycles;
        int validSeen;
        lowCycles = 0;
        validSeen = 0;
        while (!opReady && lowCycles < 200) begin
            if (resValid) validSeen++;
            lowCycles++;
            @(negedge clk);
        end
        checkOutput({name, ":quiesceLength"}, 64'(lowCycles), 64'(QC));
        checkOutput({name, ":noResult"}, 64'(validSeen), 64'(0));
    endtask

    initial begin
        logic [2:0]   f;
        logic [W-1:0] a;
        logic [W-1:0] b;
        rst      = 1'b1;
        opValid  = 1'b0;
        funct3   = '0;
        rs1      = '0;
        rs2      = '0;
        rd       = '0;
        resReady = 1'b0;
        repeat (3) @(negedge clk);

        checkOutput("reset:opReady", 64'(opReady), 64'(0));
        checkOutput("reset:divLoad", 64'(divLoad), 64'(0));
        checkOutput("reset:resValid", 64'(resValid), 64'(0));
        checkOutput("reset:resData", 64'(resData), 64'(0));
        checkOutput("reset:resRd", 64'(resRd), 64'(0));
        checkOutput("reset:divSigned", 64'(divSigned), 64'(0));
        checkOutput("reset:dividend", 64'(divDividend), 64'(0));
        checkOutput("reset:divisor", 64'(divDivisor), 64'(0));
        rst = 1'b0;
        quiesceCheck("powerUp");

        runTransaction("divu100by7", 3'b101, 32'd100, 32'd7, 5'd3, 0);
        runTransaction("remNeg7by2", 3'b110, 32'hFFFF_FFF9, 32'd2, 5'd4, 1);
        runTransaction("divNeg7by2", 3'b100, 32'hFFFF_FFF9, 32'd2, 5'd5, 0);
        runTransaction("div5by0", 3'b100, 32'd5, 32'd0, 5'd6, 0);
        runTransaction("remu5by0", 3'b111, 32'd5, 32'd0, 5'd7, 2);
        runTransaction("divOverflow", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 0);
        runTransaction("remOverflow", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 0);
        runTransaction("divuOverflowPattern", 3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 0);
        runTransaction("unknownFunct3", 3'b010, 32'd50, 32'd6, 5'd11, 0);
        runTransaction("stall10", 3'b101, 32'd1000, 32'd10, 5'd12, 10);

        applyStimulus("abort", 3'b101, 32'd1000, 32'd3, 5'd13);
        repeat (10) @(negedge clk);
        checkOutput("abort:midWaitNotReady", 64'(opReady), 64'(0));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abort:resDataCleared", 64'(resData), 64'(0));
        quiesceCheck("abort");
        runTransaction("divu9by3", 3'b101, 32'd9, 32'd3, 5'd14, 0);

        for (int i = 0; i < 12; i++) begin
            f = 3'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: b = '0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 20));
                default: ;
            endcase
            runTransaction($sformatf("random%0d", i), f, a, b, 5'($urandom), int'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
